bus_interrupt_controller: RTL
=============================

# bus_interrupt_controller

Parametrised interrupt controller for the 8-bit processor bus. It replaces the fixed two-line raise/ack wiring between peripherals (mouse, timer, …) and the processor. Up to eight source raise/ack pairs are merged onto one processor request line, with per-source pending latches, bus-mapped mask/pending/vector registers, and fixed or round-robin arbitration. It sits on the shared BUS_DATA/BUS_ADDR/BUS_WE bus alongside RAM, timer and the IO drivers.

## Interface
- N_SOURCES, 8, number of interrupt sources, legal range 1..8.
- BASE_ADDR, 8'hF0, base of the 4-byte register window; must be 4-aligned.
- RR_MODE, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- CLK  in  1  system clock; one clock domain.
- RESET  in  1  asynchronous, active-high reset.
- BUS_DATA  inout  8  shared data bus; driven only during a register read, high-Z otherwise.
- BUS_ADDR  in  8  bus address.
- BUS_WE  in  1  bus write enable.
- SRC_RAISE  in  N_SOURCES  peripheral raise lines; a source holds its line high until acked.
- SRC_ACK  out  N_SOURCES  one-cycle ack pulse back to the granted source.
- CPU_IRQ  out  1  request to the processor.
- CPU_ACK  in  1  processor acknowledge for the current request.

## Operation
- Registers at BASE_ADDR+offset:
  - +0 PENDING: read; write-1-to-clear.
  - +1 MASK: read/write; 1 = enabled.
  - +2 VECTOR: read-only; bit7 = valid, bits2:0 = granted index.
  - +3 CTRL: bit0 = global enable; other bits read 0.
- Register bits at or above N_SOURCES read 0 and ignore writes.
- Edge capture: raise_q samples SRC_RAISE every cycle. A 0→1 transition sets pending[i]. A level held high does not re-set pending after it is cleared.
- Eligible = pending & mask, gated by CTRL.bit0.
- FSM states and transitions:
  - IDLE → ARB when any source is eligible.
  - ARB: the irq_arbiter picks the winner g, latches it into VECTOR (valid=1), then → REQUEST.
  - REQUEST: CPU_IRQ=1. Sampling CPU_ACK=1 → ACK.
  - ACK: SRC_ACK[g]=1, pending[g] cleared, VECTOR.valid cleared, RR pointer set to g, then → IDLE.
- Fixed mode: the lowest eligible index wins.
- RR mode: the search starts at (ptr+1) mod N_SOURCES. ptr resets to N_SOURCES-1, so index 0 is searched first after reset.
- Request withdrawal: if CTRL.bit0 is cleared, or pending[g] is cleared by software, while in ARB or REQUEST, the FSM returns to IDLE. CPU_IRQ drops, no SRC_ACK is issued, and the remaining pending bits are kept.
- Mask changes during REQUEST do not withdraw the latched request.
- Simultaneous events:
  - A new edge on i in the same cycle as a W1C clear of i: set wins.
  - A new edge on g in the same cycle as the ACK clear: pending[g] stays 1.
  - CPU_ACK outside REQUEST is ignored.
- Reset values:
  - CPU_IRQ=0, SRC_ACK=0, BUS_DATA high-Z.
  - PENDING=0, MASK=0, CTRL=0, VECTOR=0.
  - raise_q=0, ptr=N_SOURCES-1, state IDLE.
- Reset mid-request returns all of the above immediately (asynchronously).

## Timing
- An edge sampled at clock edge k sets pending after k.
- IDLE→ARB at k+1; ARB→REQUEST at k+2. CPU_IRQ is high from k+2, so request latency is 2 cycles.
- CPU_ACK sampled at edge m:
  - SRC_ACK[g] is high for exactly the cycle after m.
  - CPU_IRQ is low after m.
  - The next request can assert no earlier than m+3.
- Register writes take effect at the sampling edge.
- Register reads: the address is sampled at edge n and BUS_DATA is driven for the cycle after n, then released. This matches RAM read latency.
- All outputs are registered. No combinational path from bus inputs or SRC_RAISE to CPU_IRQ or SRC_ACK.

## Structure
- Package bus_irq_pkg holds:
  - the state enum (IDLE, ARB, REQUEST, ACK);
  - register offsets (OFF_PENDING=0, OFF_MASK=1, OFF_VECTOR=2, OFF_CTRL=3);
  - the VECTOR valid-bit position.
- Sub-module irq_arbiter: a combinational find-first over the eligible vector.
  - Inputs: eligible, ptr, RR_MODE.
  - Outputs: grant index and found flag.
  - Reused by any later multi-master arbiter.
- The top holds the edge capture, register file, bus tri-state and FSM.

## Test plan
- **Basic request/ack:** reset, write MASK=8'h01, CTRL=1, pulse SRC_RAISE[0] high → CPU_IRQ high 2 cycles later; VECTOR reads 8'h80. Assert CPU_ACK → SRC_ACK[0] one cycle, PENDING reads 0.
- **Fixed priority:** MASK=8'hFF, raise sources 5 and 2 in the same cycle → VECTOR=8'h82 first. After ack → VECTOR=8'h85.
- **Round-robin:** RR_MODE=1, sources 1 and 3 held pending and re-raised after each ack → grants alternate 1,3,1,3. The first grant after reset is 1.
- **Masking and withdrawal:** raise source 4 with MASK=0 → no CPU_IRQ, PENDING=8'h10. Set MASK bit4 → CPU_IRQ asserts. Clear CTRL.bit0 in REQUEST → CPU_IRQ drops, no SRC_ACK, PENDING stays 8'h10.
- **Simultaneous set/clear:** write PENDING=8'h04 (W1C) in the same cycle as a new edge on source 2 → PENDING bit2 remains 1.
- **Reset mid-operation:** assert RESET while CPU_IRQ=1 → CPU_IRQ, SRC_ACK, PENDING, MASK all 0 immediately; BUS_DATA high-Z.

Source files
------------

// File: rtl/bus_irq_pkg.sv
// Shared definitions for the bus interrupt controller: FSM encoding, register
// offsets within the 4-byte window and the VECTOR valid-bit position.
package bus_irq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ARB     = 2'd1;
    localparam state_t ST_REQUEST = 2'd2;
    localparam state_t ST_ACK     = 2'd3;

    localparam logic [1:0] OFF_PENDING = 2'd0;
    localparam logic [1:0] OFF_MASK    = 2'd1;
    localparam logic [1:0] OFF_VECTOR  = 2'd2;
    localparam logic [1:0] OFF_CTRL    = 2'd3;

    localparam int VEC_VALID_BIT = 7;

endpackage

// File: rtl/irq_arbiter.sv
// Combinational find-first over an eligible vector, either lowest-index-wins
// or rotating from the slot after the last granted index.
module irq_arbiter #(
    parameter int N_SOURCES = 8
) (
    input  logic [N_SOURCES-1:0] eligible_i,
    input  logic [2:0]           ptr_i,
    input  logic                 rr_mode_i,
    output logic [2:0]           grant_o,
    output logic                 found_o
);

    logic [2:0] scanIdx;

    // The first hit in scan order wins; later hits are ignored via found_o.
    always_comb begin
        grant_o = '0;
        found_o = 1'b0;
        scanIdx = '0;
        for (int i = 0; i < N_SOURCES; i++) begin
            scanIdx = rr_mode_i ? 3'((int'(ptr_i) + 1 + i) % N_SOURCES) : 3'(i);
            if (!found_o && eligible_i[scanIdx]) begin
                found_o = 1'b1;
                grant_o = scanIdx;
            end
        end
    end

endmodule

// File: rtl/bus_interrupt_controller.sv
// Merges up to eight peripheral raise/ack pairs onto one processor request,
// with bus-mapped PENDING/MASK/VECTOR/CTRL registers at BASE_ADDR.
module bus_interrupt_controller
    import bus_irq_pkg::*;
#(
    parameter int         N_SOURCES = 8,
    parameter logic [7:0] BASE_ADDR = 8'hF0,
    parameter bit         RR_MODE   = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    inout  wire  [7:0]           BUS_DATA,
    input  logic [7:0]           BUS_ADDR,
    input  logic                 BUS_WE,
    input  logic [N_SOURCES-1:0] SRC_RAISE,
    output logic [N_SOURCES-1:0] SRC_ACK,
    output logic                 CPU_IRQ,
    input  logic                 CPU_ACK
);

    localparam logic [2:0] PTR_RESET = 3'(N_SOURCES - 1);

    state_t               state_q, state_d;
    logic [N_SOURCES-1:0] raise_q;
    logic [N_SOURCES-1:0] pending_q, pending_d;
    logic [N_SOURCES-1:0] mask_q, mask_d;
    logic                 ctrlEn_q, ctrlEn_d;
    logic                 vecValid_q, vecValid_d;
    logic [2:0]           grantIdx_q, grantIdx_d;
    logic [2:0]           ptr_q, ptr_d;
    logic                 cpuIrq_q, cpuIrq_d;
    logic [N_SOURCES-1:0] srcAck_q, srcAck_d;
    logic                 rdEn_q, rdEn_d;
    logic [7:0]           rdData_q, rdData_d;

    logic                 inWindow;
    logic [1:0]           regOffset;
    logic                 wrEn;
    logic [N_SOURCES-1:0] busWrData;
    logic [N_SOURCES-1:0] riseEdge;
    logic [N_SOURCES-1:0] w1cClr;
    logic [N_SOURCES-1:0] ackClr;
    logic [N_SOURCES-1:0] eligible;
    logic [2:0]           arbGrant;
    logic                 arbFound;
    logic                 withdraw;
    logic [7:0]           pendingPad, maskPad, vectorPad;

    assign inWindow  = (BUS_ADDR[7:2] == BASE_ADDR[7:2]);
    assign regOffset = BUS_ADDR[1:0];
    assign wrEn      = inWindow && BUS_WE;
    assign busWrData = BUS_DATA[N_SOURCES-1:0];
    assign riseEdge  = SRC_RAISE & ~raise_q;
    assign w1cClr    = (wrEn && regOffset == OFF_PENDING) ? busWrData : '0;
    assign eligible  = ctrlEn_q ? (pending_q & mask_q) : '0;
    assign withdraw  = !ctrlEn_q || !pending_q[grantIdx_q];

    irq_arbiter #(
        .N_SOURCES (N_SOURCES)
    ) u_arbiter (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .rr_mode_i  (RR_MODE),
        .grant_o    (arbGrant),
        .found_o    (arbFound)
    );

    // A fresh edge is OR-ed in last so it beats both W1C and the ACK clear.
    always_comb begin
        state_d    = state_q;
        cpuIrq_d   = cpuIrq_q;
        srcAck_d   = '0;
        vecValid_d = vecValid_q;
        grantIdx_d = grantIdx_q;
        ptr_d      = ptr_q;
        ackClr     = '0;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (arbFound) begin
                    grantIdx_d = arbGrant;
                    vecValid_d = 1'b1;
                    cpuIrq_d   = 1'b1;
                    state_d    = ST_REQUEST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQUEST: begin
                if (withdraw) begin
                    cpuIrq_d   = 1'b0;
                    vecValid_d = 1'b0;
                    state_d    = ST_IDLE;
                end else if (CPU_ACK) begin
                    cpuIrq_d             = 1'b0;
                    srcAck_d[grantIdx_q] = 1'b1;
                    state_d              = ST_ACK;
                end
            end
            ST_ACK: begin
                ackClr[grantIdx_q] = 1'b1;
                vecValid_d         = 1'b0;
                ptr_d              = grantIdx_q;
                state_d            = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        pending_d = (pending_q & ~w1cClr & ~ackClr) | riseEdge;
    end

    always_comb begin
        mask_d   = mask_q;
        ctrlEn_d = ctrlEn_q;
        if (wrEn && regOffset == OFF_MASK) mask_d = busWrData;
        if (wrEn && regOffset == OFF_CTRL) ctrlEn_d = BUS_DATA[0];
    end

    // Bits at or above N_SOURCES are tied to zero on readback.
    always_comb begin
        pendingPad                   = '0;
        maskPad                      = '0;
        vectorPad                    = '0;
        pendingPad[N_SOURCES-1:0]    = pending_q;
        maskPad[N_SOURCES-1:0]       = mask_q;
        vectorPad[VEC_VALID_BIT]     = vecValid_q;
        vectorPad[2:0]               = grantIdx_q;
        rdEn_d                       = inWindow && !BUS_WE;
        case (regOffset)
            OFF_PENDING: rdData_d = pendingPad;
            OFF_MASK:    rdData_d = maskPad;
            OFF_VECTOR:  rdData_d = vectorPad;
            default:     rdData_d = {7'b0, ctrlEn_q};
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            raise_q    <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            ctrlEn_q   <= 1'b0;
            vecValid_q <= 1'b0;
            grantIdx_q <= '0;
            ptr_q      <= PTR_RESET;
            cpuIrq_q   <= 1'b0;
            srcAck_q   <= '0;
            rdEn_q     <= 1'b0;
            rdData_q   <= '0;
        end else begin
            state_q    <= state_d;
            raise_q    <= SRC_RAISE;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            ctrlEn_q   <= ctrlEn_d;
            vecValid_q <= vecValid_d;
            grantIdx_q <= grantIdx_d;
            ptr_q      <= ptr_d;
            cpuIrq_q   <= cpuIrq_d;
            srcAck_q   <= srcAck_d;
            rdEn_q     <= rdEn_d;
            rdData_q   <= rdData_d;
        end
    end

    assign BUS_DATA = rdEn_q ? rdData_q : 8'bz;
    assign CPU_IRQ  = cpuIrq_q;
    assign SRC_ACK  = srcAck_q;

endmodule
